// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 memory-port arbiter and the memory stage.
//  - arb_state_e : arbiter FSM states (idle / request in flight / response pulse)
//  - arb_side_e  : which requester owns the current access (fetch or data)
//  - AlignMask   : byte-offset bits that must be zero for an 8-byte word access
//  - StatAok/StatAdr : Y86 status codes (SAOK/SADR) consumed by the memory stage
package y86_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    typedef enum logic {
        SideI = 1'b0,
        SideD = 1'b1
    } arb_side_e;

    localparam logic [2:0] AlignMask = 3'b111;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatAdr = 3'd3;

    function automatic logic is_misaligned(input logic [2:0] addr_lsbs);
        return (addr_lsbs & AlignMask) != 3'b000;
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Watchdog counter for an outstanding backing-memory request.
//  clk_i, rst_i : clock, synchronous active-high reset
//  clear_i      : force count to zero (held while no request is in flight)
//  en_i         : count one cycle of waiting
//  expired_o    : count has reached TIMEOUT-1; the current cycle is the last one allowed
module arb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between fetch (I-side, read-only) and the memory stage
// (D-side, read/write). D-side wins contention, but after MAX_D_RUN consecutive D grants
// with fetch waiting, fetch is granted. Misaligned accesses complete with an error without
// touching memory; a request that sees no mem_ack_i within TIMEOUT cycles aborts with error.
//  i_req_i/i_addr_i                     fetch request          -> i_done_o, i_rdata_o, i_err_o
//  d_req_i/d_we_i/d_addr_i/d_wdata_i    data request           -> d_done_o, d_rdata_o, d_err_o
//  mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  backing-memory request
//  mem_ack_i/mem_rdata_i/mem_err_i      backing-memory completion
//  busy_o                               an access is in progress
module mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_D_RUN = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_done_o,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_err_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_done_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,
    output logic              busy_o
);

    localparam int unsigned DRunW = $clog2(MAX_D_RUN + 1);

    arb_state_e        state_q, state_d;
    arb_side_e         side_q, side_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DRunW-1:0]  d_run_q, d_run_d;

    logic              tmo_expired;
    logic              grant_d;
    logic [ADDR_W-1:0] sel_addr;
    // Completion bookkeeping: which side finishes this cycle and with what read data.
    logic              cpl;
    arb_side_e         cpl_side;
    logic              cpl_we;
    logic [DATA_W-1:0] cpl_rdata;

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != StReq),
        .en_i      (state_q == StReq),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        side_d    = side_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        d_run_d   = d_run_q;
        grant_d   = 1'b0;
        sel_addr  = i_addr_i;
        cpl       = 1'b0;
        cpl_side  = side_q;
        cpl_we    = we_q;
        cpl_rdata = '0;

        case (state_q)
            StIdle: begin
                if (i_req_i || d_req_i) begin
                    grant_d  = d_req_i && !(i_req_i && (d_run_q == DRunW'(MAX_D_RUN)));
                    sel_addr = grant_d ? d_addr_i : i_addr_i;
                    side_d   = grant_d ? SideD : SideI;
                    we_d     = grant_d && d_we_i;
                    addr_d   = sel_addr;
                    wdata_d  = grant_d ? d_wdata_i : '0;
                    // The streak only grows while fetch is actually being held off.
                    if (grant_d && i_req_i) begin
                        if (d_run_q != DRunW'(MAX_D_RUN)) begin
                            d_run_d = d_run_q + DRunW'(1);
                        end
                    end else begin
                        d_run_d = '0;
                    end
                    if (is_misaligned(sel_addr[2:0])) begin
                        state_d  = StResp;
                        err_d    = 1'b1;
                        cpl      = 1'b1;
                        cpl_side = side_d;
                        cpl_we   = we_d;
                    end else begin
                        state_d = StReq;
                        err_d   = 1'b0;
                    end
                end
            end
            StReq: begin
                if (mem_ack_i) begin
                    state_d   = StResp;
                    err_d     = mem_err_i;
                    cpl       = 1'b1;
                    cpl_rdata = mem_rdata_i;
                end else if (tmo_expired) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    cpl     = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Writes never disturb the D-side read-data register.
        if (cpl) begin
            if (cpl_side == SideI) begin
                i_rdata_d = cpl_rdata;
            end else if (!cpl_we) begin
                d_rdata_d = cpl_rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            side_q    <= SideI;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            d_run_q   <= '0;
        end else begin
            state_q   <= state_d;
            side_q    <= side_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            d_run_q   <= d_run_d;
        end
    end

    assign i_done_o    = (state_q == StResp) && (side_q == SideI);
    assign d_done_o    = (state_q == StResp) && (side_q == SideD);
    assign i_err_o     = i_done_o && err_q;
    assign d_err_o     = d_done_o && err_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_req_o   = (state_q == StReq);
    assign mem_we_o    = (state_q == StReq) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The bench plays both requesters and the backing
// memory; a transaction-level model predicts grant side, latency, error and read data.
module tb_mem_port_arbiter;

    localparam int MaxDRun = 4;
    localparam int Timeout = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_done;
    logic [63:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    int          drun = 0;
    logic [63:0] exp_i_rd = '0;
    logic [63:0] exp_d_rd = '0;
    logic [63:0] mem_model [logic [63:0]];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .i_req_i     (i_req),
        .i_addr_i    (i_addr),
        .i_done_o    (i_done),
        .i_rdata_o   (i_rdata),
        .i_err_o     (i_err),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_done_o    (d_done),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .mem_err_i   (mem_err),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    function automatic logic [63:0] rnd_addr();
        logic [63:0] a;
        a = 64'($urandom_range(0, 31)) << 3;
        if ($urandom_range(0, 5) == 0) a = a + 64'($urandom_range(1, 7));
        return a;
    endfunction

    // Runs one access from an IDLE negedge with requests already driven; returns at the
    // following IDLE negedge with the granted request dropped.
    task automatic run_txn(input string tag, input int ack_delay, input bit no_ack,
                           input bit ack_err, output bit got_d);
        bit          exp_d, ewe, mis, exp_err, done_seen;
        logic [63:0] ea, ew, ack_val, exp_val;
        int          exp_reqs, exp_lat, cyc, reqs;

        if (i_req && d_req) exp_d = (drun != MaxDRun);
        else                exp_d = d_req;
        if (exp_d && i_req) drun = (drun < MaxDRun) ? drun + 1 : MaxDRun;
        else                drun = 0;
        ea       = exp_d ? d_addr : i_addr;
        ewe      = exp_d && d_we;
        ew       = exp_d ? d_wdata : 64'h0;
        mis      = (ea % 8) != 0;
        exp_reqs = mis ? 0 : (no_ack ? Timeout : ack_delay + 1);
        exp_lat  = mis ? 1 : exp_reqs + 1;

        cyc = 0; reqs = 0; done_seen = 0; ack_val = '0;
        while (!done_seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            mem_err = 1'b0;
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    check({tag, " mem_addr"}, mem_addr, ea);
                    check({tag, " mem_we"}, 64'(mem_we), 64'(ewe));
                    check({tag, " mem_wdata"}, mem_wdata, ew);
                end
                if (!no_ack && reqs == ack_delay + 1) begin
                    ack_val   = ewe ? {$urandom, $urandom} : mem_read(ea);
                    mem_ack   = 1'b1;
                    mem_err   = ack_err;
                    mem_rdata = ack_val;
                end
            end
            if (i_done || d_done) done_seen = 1;
        end

        exp_err = mis || no_ack || ack_err;
        exp_val = (mis || no_ack) ? 64'h0 : ack_val;
        if (!exp_d)    exp_i_rd = exp_val;
        else if (!ewe) exp_d_rd = exp_val;
        if (ewe && !exp_err) mem_model[ea] = ew;

        got_d = d_done;
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " req_cycles"}, 64'(reqs), 64'(exp_reqs));
        check({tag, " done_side"}, {62'h0, i_done, d_done}, {62'h0, !exp_d, exp_d});
        check({tag, " err"}, 64'(exp_d ? d_err : i_err), 64'(exp_err));
        check({tag, " i_rdata"}, i_rdata, exp_i_rd);
        check({tag, " d_rdata"}, d_rdata, exp_d_rd);

        if (exp_d) d_req = 1'b0;
        else       i_req = 1'b0;
        @(negedge clk);
        check({tag, " idle_after"}, {62'h0, busy, i_done | d_done}, 64'h0);
    endtask

    initial begin
        bit   got_d;
        logic [5:0] order;
        int   dly;
        bit   na, er;

        rst = 1'b1; mem_ack = 0; mem_err = 0; mem_rdata = '0;
        i_req = 1'b1; i_addr = 64'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80; d_wdata = 64'h0;

        // 1: reset with both requests present
        repeat (3) begin
            @(negedge clk);
            check("rst ctl", {57'h0, mem_req, mem_we, busy, i_done, d_done, i_err, d_err}, 64'h0);
            check("rst mem_addr", mem_addr, 64'h0);
            check("rst rdata", i_rdata | d_rdata | mem_wdata, 64'h0);
        end
        rst = 1'b0;
        run_txn("rst_release", 0, 0, 0, got_d);
        check("rst_release grant", 64'(got_d), 64'h1);
        i_req = 1'b0;

        // 2: single fetch
        mem_model[64'h100] = 64'hDEAD_BEEF;
        i_req = 1'b1; i_addr = 64'h100;
        run_txn("fetch", 0, 0, 0, got_d);
        check("fetch rdata", i_rdata, 64'hDEAD_BEEF);

        // 3: contention, requests re-raised after each done
        order = '0;
        for (int k = 0; k < 6; k++) begin
            if (!i_req) begin i_req = 1'b1; i_addr = 64'h200 + 64'(k * 8); end
            if (!d_req) begin
                d_req = 1'b1; d_we = 1'(k & 1); d_addr = 64'h300 + 64'(k * 8);
                d_wdata = 64'h1111_0000 + 64'(k);
            end
            run_txn("contend", k % 2, 0, 0, got_d);
            order = {order[4:0], got_d};
        end
        check("contend order", 64'(order), 64'(6'b111101));
        i_req = 1'b0; d_req = 1'b0;

        // 4: misaligned data access
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h103;
        run_txn("misalign", 0, 0, 0, got_d);

        // 5: timeout on fetch
        i_req = 1'b1; i_addr = 64'h200;
        run_txn("timeout", 0, 1, 0, got_d);
        check("timeout rdata", i_rdata, 64'h0);

        // 6: reset in the third REQ cycle, late ack ignored
        i_req = 1'b1; i_addr = 64'h300;
        repeat (3) @(negedge clk);
        check("midrst req3", 64'(mem_req), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst drop", {61'h0, mem_req, busy, i_done}, 64'h0);
        rst = 1'b0; i_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'h1234_5678; mem_err = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; mem_err = 1'b0;
        check("late_ack ignored", {62'h0, busy, i_done | d_done}, 64'h0);
        @(negedge clk);
        check("late_ack nodone", {62'h0, busy, i_done | d_done}, 64'h0);
        check("late_ack rdata", i_rdata | d_rdata, 64'h0);
        drun = 0; exp_i_rd = '0; exp_d_rd = '0;

        // Randomized traffic; a pending request keeps its address until it completes.
        for (int n = 0; n < 80; n++) begin
            if (!i_req && $urandom_range(0, 2) != 0) begin
                i_req = 1'b1; i_addr = rnd_addr();
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1));
                d_wdata = {$urandom, $urandom};
            end
            if (!i_req && !d_req) begin
                d_req = 1'b1; d_addr = rnd_addr(); d_we = 1'b0;
            end
            dly = $urandom_range(0, 3);
            na  = ($urandom_range(0, 19) == 0);
            er  = ($urandom_range(0, 7) == 0);
            run_txn("rand", dly, na, er, got_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
